// File: rtl/dm_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the COMPARE reset value.
package dm_mmio_pkg;

   // Byte offsets of the registers inside the 16-byte MMIO window
   localparam logic [3:0] OFS_TXDATA  = 4'h0;
   localparam logic [3:0] OFS_STATUS  = 4'h4;
   localparam logic [3:0] OFS_COUNT   = 4'h8;
   localparam logic [3:0] OFS_COMPARE = 4'hC;

   // STATUS read bit positions
   localparam int ST_EXPIRED = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_FULL    = 2;
   // STATUS write bit that loads the interrupt enable (DM_IRQ_EN builds)
   localparam int ST_IE      = 1;

   // COMPARE powers up at all-ones so the timer does not expire soon after reset
   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/dm_tx_fifo.sv
// Byte FIFO feeding the TX egress. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
// Head byte reads 0 while empty so egress data is clean after reset.
module dm_tx_fifo
   import dm_mmio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [7:0]    mem_r [DEPTH];
   logic          push_ok_s;
   logic          pop_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Pointer update; reset discards any queued bytes
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
   end

   // Head byte from registered state only, zero when nothing is queued
   always_comb begin
      head = 8'h00;
      if (empty) begin
         head = 8'h00;
      end else begin
         head = mem_r[rd_ptr_r[AW-1:0]];
      end
   end

endmodule

// File: rtl/dm_mmio_responder.sv
// Data-memory responder on the EX/MEM port: word RAM below MMIO_BASE and a
// 16-byte register window (TX FIFO, STATUS, free-running COUNT, COMPARE) at
// MMIO_BASE. Stalls the MEM stage while a TXDATA write meets a full FIFO.
// Optional feature macro: DM_IRQ_EN adds an interrupt enable flop (STATUS
// write bit 1) and drives irq = expired & IE; otherwise irq is tied low.
module dm_mmio_responder
   import dm_mmio_pkg::*;
#(
   parameter int          RAM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_address,
   input  logic [31:0] data_in,
   input  logic        dm_r,
   input  logic        dm_w,
   output logic [31:0] data_out,
   output logic        stall,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam int RAM_AW = $clog2(RAM_WORDS);

   logic [31:0]       ram_r [RAM_WORDS];
   logic [31:0]       count_r;
   logic [31:0]       compare_r;
   logic              expired_r;
   logic              expired_nxt_s;
   logic [31:0]       mmio_ofs_s;
   logic [1:0]        wofs_s;
   logic              mmio_sel_s;
   logic              win_hit_s;
   logic              txdata_wr_s;
   logic              status_wr_s;
   logic              count_wr_s;
   logic              compare_wr_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              push_s;
   logic              pop_s;
   logic [RAM_AW-1:0] ram_idx_s;
   logic [31:0]       status_s;
   logic [31:0]       rdata_s;
   logic              unused_s;

   // Address decode: the window is the 16 bytes starting at MMIO_BASE;
   // anything above it is inside MMIO space but unmapped
   assign mmio_sel_s   = (data_address >= MMIO_BASE);
   assign mmio_ofs_s   = data_address - MMIO_BASE;
   assign win_hit_s    = mmio_sel_s && (mmio_ofs_s[31:4] == 28'd0);
   assign wofs_s       = mmio_ofs_s[3:2];
   assign unused_s     = ^mmio_ofs_s[1:0];
   assign ram_idx_s    = data_address[RAM_AW+1:2];

   assign txdata_wr_s  = dm_w && win_hit_s && (wofs_s == OFS_TXDATA[3:2]);
   assign status_wr_s  = dm_w && win_hit_s && (wofs_s == OFS_STATUS[3:2]);
   assign count_wr_s   = dm_w && win_hit_s && (wofs_s == OFS_COUNT[3:2]);
   assign compare_wr_s = dm_w && win_hit_s && (wofs_s == OFS_COMPARE[3:2]);

   // Stall only when a TXDATA write meets a full FIFO (registered full flag)
   assign stall    = txdata_wr_s & fifo_full_s;
   assign push_s   = txdata_wr_s & ~fifo_full_s;
   assign tx_valid = ~fifo_empty_s;
   assign pop_s    = tx_valid & tx_ready;

   dm_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (data_in[7:0]),
      .pop       (pop_s),
      .head      (tx_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign status_s = {29'd0, fifo_full_s, fifo_empty_s, expired_r};

   // Word RAM write; contents survive reset
   always_ff @(posedge clk) begin
      if (dm_w && !mmio_sel_s && !stall) ram_r[ram_idx_s] <= data_in;
   end

   // Read mux: combinational, returns pre-write values on read+write cycles
   always_comb begin
      rdata_s = 32'd0;
      if (!dm_r) begin
         rdata_s = 32'd0;
      end else if (!mmio_sel_s) begin
         rdata_s = ram_r[ram_idx_s];
      end else if (!win_hit_s) begin
         rdata_s = 32'd0;
      end else begin
         case (wofs_s)
            OFS_STATUS[3:2]:  rdata_s = status_s;
            OFS_COUNT[3:2]:   rdata_s = count_r;
            OFS_COMPARE[3:2]: rdata_s = compare_r;
            default:          rdata_s = 32'd0;
         endcase
      end
   end
   assign data_out = rdata_s;

   // Sticky expired flag: a match sets it and wins over a STATUS-write clear
   always_comb begin
      expired_nxt_s = expired_r;
      if (count_r == compare_r) begin
         expired_nxt_s = 1'b1;
      end else begin
         expired_nxt_s = expired_r & ~status_wr_s;
      end
   end

   // Timer registers; a CPU write to COUNT takes priority over the increment
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r   <= 32'd0;
         compare_r <= COMPARE_RST;
         expired_r <= 1'b0;
      end else begin
         if (count_wr_s) begin
            count_r <= data_in;
         end else begin
            count_r <= count_r + 32'd1;
         end
         if (compare_wr_s) compare_r <= data_in;
         expired_r <= expired_nxt_s;
      end
   end

`ifdef DM_IRQ_EN
   logic ie_r;
   logic ie_nxt_s;
   logic irq_r;

   // Interrupt enable follows STATUS write bit 1
   always_comb begin
      ie_nxt_s = ie_r;
      if (status_wr_s) begin
         ie_nxt_s = data_in[ST_IE];
      end else begin
         ie_nxt_s = ie_r;
      end
   end

   // irq is registered from next-state values so it tracks expired & IE exactly
   always_ff @(posedge clk) begin
      if (!reset) begin
         ie_r  <= 1'b0;
         irq_r <= 1'b0;
      end else begin
         ie_r  <= ie_nxt_s;
         irq_r <= expired_nxt_s & ie_nxt_s;
      end
   end
   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Bench for dm_mmio_responder: a behavioural model (queue FIFO, integer timer,
// sparse RAM) is compared against every output each cycle, plus literal checks.
module tb_dm_mmio_responder;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_address;
   logic [31:0] data_in;
   logic        dm_r;
   logic        dm_w;
   logic [31:0] data_out;
   logic        stall;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   // model state
   logic [7:0]  m_q [$];
   logic [31:0] m_ram [int];
   logic [31:0] m_cnt;
   logic [31:0] m_cmp;
   logic        m_exp;
   logic        m_ie;

   dm_mmio_responder #(
      .RAM_WORDS  (1024),
      .FIFO_DEPTH (DEPTH),
      .MMIO_BASE  (BASE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_address (data_address),
      .data_in      (data_in),
      .dm_r         (dm_r),
      .dm_w         (dm_w),
      .data_out     (data_out),
      .stall        (stall),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] a;
         logic [31:0] exp_do;
         logic        known;
         logic        full;
         a     = {data_address[31:2], 2'b00};
         full  = (m_q.size() == DEPTH);
         known = 1'b1;
         exp_do = 32'd0;
         if (dm_r) begin
            if (a < BASE) begin
               if (m_ram.exists(int'(a[11:2]))) exp_do = m_ram[int'(a[11:2])];
               else known = 1'b0;
            end else if (a == BASE + 32'd4) exp_do = {29'd0, full, m_q.size() == 0, m_exp};
            else if (a == BASE + 32'd8)     exp_do = m_cnt;
            else if (a == BASE + 32'd12)    exp_do = m_cmp;
            else                            exp_do = 32'd0;
         end
         if (known) chk("data_out", data_out, exp_do);
         chk("stall", {31'd0, stall}, {31'd0, dm_w && (a == BASE) && full});
         chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
         chk("tx_data", {24'd0, tx_data}, {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
`ifdef DM_IRQ_EN
         chk("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
`else
         chk("irq", {31'd0, irq}, 32'd0);
`endif
      end
   end

   // Model update at each active edge
   always @(posedge clk) begin
      if (!reset) begin
         m_q.delete();
         m_cnt = 32'd0;
         m_cmp = 32'hFFFF_FFFF;
         m_exp = 1'b0;
         m_ie  = 1'b0;
      end else begin
         logic [31:0] a;
         logic        full, do_pop, do_push, st_wr, new_exp;
         a       = {data_address[31:2], 2'b00};
         full    = (m_q.size() == DEPTH);
         do_pop  = (m_q.size() > 0) && tx_ready;
         do_push = dm_w && (a == BASE) && !full;
         st_wr   = dm_w && (a == BASE + 32'd4);
         new_exp = (m_cnt == m_cmp) || (m_exp && !st_wr);
         if (st_wr) m_ie = data_in[1];
         if (dm_w && a == BASE + 32'd8) m_cnt = data_in;
         else m_cnt = m_cnt + 32'd1;
         if (dm_w && a == BASE + 32'd12) m_cmp = data_in;
         m_exp = new_exp;
         if (dm_w && a < BASE) m_ram[int'(a[11:2])] = data_in;
         if (do_pop) void'(m_q.pop_front());
         if (do_push) m_q.push_back(data_in[7:0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
      data_address = a;
      data_in      = d;
      dm_r         = r;
      dm_w         = w;
   endtask

   initial begin
      reset    = 1'b0;
      tx_ready = 1'b0;
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      step();

      // 1: RAM write/read, neighbour unchanged, read-during-write
      drive(32'h104, 32'h1111_1111, 1'b0, 1'b1); step();
      drive(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1); step();
      drive(32'h100, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("ram_rd100", data_out, 32'hDEAD_BEEF); step();
      drive(32'h104, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("ram_rd104", data_out, 32'h1111_1111); step();
      drive(32'h100, 32'hCAFE_F00D, 1'b1, 1'b1);
      @(negedge clk); chk("ram_rw_old", data_out, 32'hDEAD_BEEF); step();
      drive(32'h100, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("ram_rw_new", data_out, 32'hCAFE_F00D); step();

      // 2: fill FIFO, stall on 9th, pop releases it, drain in order
      for (int i = 0; i < 8; i++) begin
         drive(BASE, 32'hA0 + i, 1'b0, 1'b1);
         @(negedge clk); chk("fill_stall", {31'd0, stall}, 32'd0);
         step();
      end
      drive(BASE, 32'hA8, 1'b0, 1'b1);
      @(negedge clk); chk("full_stall", {31'd0, stall}, 32'd1); step();
      tx_ready = 1'b1;
      @(negedge clk); chk("pop_stall", {31'd0, stall}, 32'd1);
      chk("pop_head", {24'd0, tx_data}, 32'hA0); step();
      tx_ready = 1'b0;
      @(negedge clk); chk("retry_stall", {31'd0, stall}, 32'd0); step();
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      tx_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); chk("drain", {24'd0, tx_data}, 32'hA1 + k);
         step();
      end
      tx_ready = 1'b0;
      @(negedge clk); chk("drained", {31'd0, tx_valid}, 32'd0);
      drive(BASE, 32'hB0, 1'b0, 1'b1); step();
      tx_ready = 1'b1;
      drive(BASE, 32'hB1, 1'b0, 1'b1);
      @(negedge clk); chk("pp_head0", {24'd0, tx_data}, 32'hB0); step();
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk); chk("pp_head1", {24'd0, tx_data}, 32'hB1); step();
      tx_ready = 1'b0;

      // 3: expired flag set, cleared, and set-wins-over-clear
      drive(BASE + 32'd8, 32'd0, 1'b0, 1'b1); step();
      drive(BASE + 32'd12, 32'd5, 1'b0, 1'b1); step();
      drive(BASE + 32'd4, 32'd0, 1'b1, 1'b0);
      repeat (4) step();
      @(negedge clk); chk("exp_before", data_out, 32'h2); step();
      @(negedge clk); chk("exp_set", data_out, 32'h3); step();
      drive(BASE + 32'd4, 32'd0, 1'b0, 1'b1); step();
      drive(BASE + 32'd4, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("exp_clr", data_out, 32'h2); step();
      drive(BASE + 32'd8, 32'd4, 1'b0, 1'b1); step();
      drive(BASE + 32'd4, 32'd0, 1'b1, 1'b0); step();
      drive(BASE + 32'd4, 32'd0, 1'b0, 1'b1); step();
      drive(BASE + 32'd4, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("exp_setwins", data_out, 32'h3); step();
      drive(BASE + 32'd4, 32'd0, 1'b0, 1'b1); step();

      // 4: COUNT wrap
      drive(BASE + 32'd8, 32'hFFFF_FFFE, 1'b0, 1'b1); step();
      drive(BASE + 32'd8, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("cnt_fe", data_out, 32'hFFFF_FFFE); step();
      @(negedge clk); chk("cnt_ff", data_out, 32'hFFFF_FFFF); step();
      @(negedge clk); chk("cnt_wrap", data_out, 32'd0); step();
      drive(BASE + 32'd32, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("unmapped", data_out, 32'd0); step();

      // 5: reset mid-operation
      drive(BASE, 32'hC1, 1'b0, 1'b1); step();
      drive(BASE, 32'hC2, 1'b0, 1'b1); step();
      drive(BASE, 32'hC3, 1'b0, 1'b1); step();
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      reset = 1'b0; step();
      reset = 1'b1;
      drive(BASE + 32'd8, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("rst_count", data_out, 32'd0);
      chk("rst_valid", {31'd0, tx_valid}, 32'd0); step();
      drive(BASE + 32'd12, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("rst_compare", data_out, 32'hFFFF_FFFF); step();
      drive(32'h100, 32'd0, 1'b1, 1'b0);
      @(negedge clk); chk("ram_kept", data_out, 32'hCAFE_F00D); step();

      // 6: interrupt
      drive(BASE + 32'd4, 32'd2, 1'b0, 1'b1); step();
      drive(BASE + 32'd8, 32'd0, 1'b0, 1'b1); step();
      drive(BASE + 32'd12, 32'd3, 1'b0, 1'b1); step();
      drive(BASE + 32'd4, 32'd0, 1'b1, 1'b0);
      repeat (3) step();
      @(negedge clk); chk("irq_status", data_out, 32'h3);
`ifdef DM_IRQ_EN
      chk("irq_on", {31'd0, irq}, 32'd1);
`else
      chk("irq_off", {31'd0, irq}, 32'd0);
`endif
      step();
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
